// File: rtl/mem_arb_pkg.sv
// Shared types and client indices for the two-client main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_t;

  localparam int unsigned CLIENT_I = 0;
  localparam int unsigned CLIENT_D = 1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone requester wins outright, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       win,
  output logic       valid
);

  // Winner selection.
  always_comb begin
    valid = |req;
    win   = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ptr;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-granular main_mem between the instruction cache (client 0)
// and the data cache (client 1). One line transaction at a time, round-robin
// between clients, owner locked until main_mem grants, then one release cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 13,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [1:0]                                    c_rd_req,
  input  logic [1:0]                                    c_wr_req,
  input  logic [1:0][ADDR_LEN-1:0]                      c_addr,
  input  logic [1:0][(1<<LINE_ADDR_LEN)-1:0][31:0]      c_wr_line,
  output logic [1:0]                                    c_gnt,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]           c_rd_line,
  output logic                                          m_rd_req,
  output logic                                          m_wr_req,
  output logic [ADDR_LEN-1:0]                           m_addr,
  output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]           m_wr_line,
  input  logic                                          m_gnt,
  input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]           m_rd_line,
  output logic [1:0][CNT_W-1:0]                         grant_cnt
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic                   r_owner;
  logic                   r_op_wr;
  logic                   r_rr_ptr;
  logic [1:0][CNT_W-1:0]  r_grant_cnt;
  logic [1:0]             w_req;
  logic                   w_win;
  logic                   w_valid;
  logic                   w_done;

  assign w_req     = c_rd_req | c_wr_req;
  assign c_rd_line = m_rd_line;
  assign grant_cnt = r_grant_cnt;

  rr_arb2 u_rr_arb2 (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .win   (w_win),
    .valid (w_valid)
  );

  // Next state, main_mem request drive and the combinational completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    m_rd_req    = 1'b0;
    m_wr_req    = 1'b0;
    m_addr      = '0;
    m_wr_line   = '0;
    c_gnt       = '0;
    w_done      = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_valid) w_state_nxt = ARB_BUSY;
      end
      ARB_BUSY: begin
        m_rd_req  = ~r_op_wr;
        m_wr_req  = r_op_wr;
        m_addr    = c_addr[r_owner];
        m_wr_line = c_wr_line[r_owner];
        // A grant in the same cycle as the owner dropping still completes:
        // main_mem saw the request and has already acted on it.
        if (m_gnt) begin
          c_gnt[r_owner] = 1'b1;
          w_done         = 1'b1;
          w_state_nxt    = ARB_RELEASE;
        end else if (!w_req[r_owner]) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_RELEASE: w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  // State register, owner/op latch on arbitration, round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ARB_IDLE;
      r_owner  <= 1'b0;
      r_op_wr  <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_IDLE && w_valid) begin
        r_owner <= w_win;
        r_op_wr <= c_wr_req[w_win];
      end
      if (w_done) r_rr_ptr <= ~r_owner;
    end
  end

  // Per-client completed-transaction counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else if (w_done) begin
      r_grant_cnt[r_owner] <= r_grant_cnt[r_owner] + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural main_mem, directed client scenarios,
// randomized client traffic, and a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AL = 13;
  localparam int LAL = 3;
  localparam int CW = 32;
  localparam int LS = 1 << LAL;

  typedef logic [LS-1:0][31:0] line_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            c_rd_req, c_wr_req;
  logic [1:0][AL-1:0]    c_addr;
  logic [1:0][LS-1:0][31:0] c_wr_line;
  logic [1:0]            c_gnt;
  line_t                 c_rd_line;
  logic                  m_rd_req, m_wr_req;
  logic [AL-1:0]         m_addr;
  line_t                 m_wr_line;
  logic                  m_gnt;
  line_t                 m_rd_line;
  logic [1:0][CW-1:0]    grant_cnt;

  int n_chk = 0;
  int n_err = 0;

  mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_addr(c_addr), .c_wr_line(c_wr_line),
    .c_gnt(c_gnt), .c_rd_line(c_rd_line),
    .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr), .m_wr_line(m_wr_line),
    .m_gnt(m_gnt), .m_rd_line(m_rd_line), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic line_t init_line(input logic [AL-1:0] a);
    line_t l;
    for (int unsigned i = 0; i < LS; i++) l[i] = {8'h5A, 3'b000, a, 8'(i)};
    return l;
  endfunction

  // ---------------- behavioural main_mem ----------------
  line_t       mem_a  [0:(1<<AL)-1];
  int unsigned lat_min = 0, lat_max = 2;
  int unsigned mem_lat = 0, mem_cnt = 0;
  bit          mem_done = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_gnt     <= 1'b0;
      m_rd_line <= '0;
      mem_cnt   = 0;
      mem_done  = 0;
      mem_lat   = $urandom_range(lat_max, lat_min);
    end else begin
      m_gnt <= 1'b0;
      if (!(m_rd_req || m_wr_req)) begin
        mem_cnt  = 0;
        mem_done = 0;
        mem_lat  = $urandom_range(lat_max, lat_min);
      end else if (!mem_done) begin
        if (mem_cnt >= mem_lat) begin
          if (m_wr_req) mem_a[m_addr] = m_wr_line;
          else          m_rd_line <= mem_a[m_addr];
          m_gnt    <= 1'b1;
          mem_done = 1;
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct { bit act; int who; bit wr; } txn_t;
  txn_t        cur = '{0, 0, 0};
  bit          cool = 0;
  int          pref = 0;
  int unsigned cnt_m [2] = '{0, 0};
  line_t       shadow [0:(1<<AL)-1];

  always @(negedge clk) begin
    logic [1:0] e_gnt;
    logic [1:0] r;
    e_gnt = 2'b00;
    if (cur.act && m_gnt) e_gnt[cur.who] = 1'b1;
    chk("m_rd_req",  m_rd_req,  cur.act && !cur.wr);
    chk("m_wr_req",  m_wr_req,  cur.act && cur.wr);
    chk("m_addr",    m_addr,    cur.act ? c_addr[cur.who] : '0);
    chk("m_wr_line", m_wr_line, cur.act ? c_wr_line[cur.who] : '0);
    chk("c_gnt",     c_gnt,     e_gnt);
    chk("c_rd_line", c_rd_line, m_rd_line);
    chk("grant_cnt0", grant_cnt[0], cnt_m[0]);
    chk("grant_cnt1", grant_cnt[1], cnt_m[1]);
    if (cur.act && !cur.wr && m_gnt) chk("rd_data", c_rd_line, shadow[c_addr[cur.who]]);
    // advance to what the next cycle must look like
    r = c_rd_req | c_wr_req;
    if (rst) begin
      cur = '{0, 0, 0}; cool = 0; pref = 0; cnt_m = '{0, 0};
    end else if (cur.act) begin
      if (m_gnt) begin
        cnt_m[cur.who]++;
        pref = 1 - cur.who;
        if (cur.wr) shadow[c_addr[cur.who]] = c_wr_line[cur.who];
        cur.act = 0;
        cool = 1;
      end else if (!r[cur.who]) begin
        cur.act = 0;
      end
    end else if (cool) begin
      cool = 0;
    end else if (r != 2'b00) begin
      cur.who = (r == 2'b11) ? pref : (r[1] ? 1 : 0);
      cur.wr  = c_wr_req[cur.who];
      cur.act = 1;
    end
  end

  // ---------------- client stimulus ----------------
  int    order[$];
  line_t got [2];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input int k, input bit wr, input logic [AL-1:0] a, input line_t l);
    c_rd_req[k] = !wr; c_wr_req[k] = wr; c_addr[k] = a; c_wr_line[k] = l;
  endtask

  task automatic drop(input int k);
    c_rd_req[k] = 1'b0; c_wr_req[k] = 1'b0;
  endtask

  // Run until every client's request has been granted; each drops after its grant.
  task automatic serve(input int budget);
    int n = 0;
    logic [1:0] g;
    while ((c_rd_req | c_wr_req) != 2'b00 && n < budget) begin
      @(negedge clk);
      g = c_gnt;
      for (int k = 0; k < 2; k++) if (g[k]) begin order.push_back(k); got[k] = c_rd_line; end
      tick();
      for (int k = 0; k < 2; k++) if (g[k]) drop(k);
      n++;
    end
    chk("serve_done", c_rd_req | c_wr_req, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1; c_rd_req = '0; c_wr_req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    line_t       l;
    int unsigned c0;
    logic [1:0]  g;
    bit          act [2];
    int          idle [2];

    for (int unsigned a = 0; a < (1 << AL); a++) begin
      mem_a[a]  = init_line(AL'(a));
      shadow[a] = init_line(AL'(a));
    end
    rst = 1'b1; c_rd_req = '0; c_wr_req = '0; c_addr = '0; c_wr_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt0", grant_cnt[0], 0);
    chk("rst_req", {m_rd_req, m_wr_req, c_gnt}, 4'b0);
    tick();

    // 1: lone read of line 5 by the icache
    req(0, 1'b0, 13'h005, '0);
    @(negedge clk); chk("t1_idle_no_req", m_rd_req, 1'b0);
    @(negedge clk); chk("t1_req_next", m_rd_req, 1'b1);
    tick();
    serve(100);
    chk("t1_data", got[0], init_line(13'h005));
    @(negedge clk); chk("t1_cnt0", grant_cnt[0], 1);
    tick();

    // 2: simultaneous reads right after reset
    do_reset();
    order.delete();
    req(0, 1'b0, 13'h007, '0); req(1, 1'b0, 13'h009, '0);
    serve(100);
    req(0, 1'b0, 13'h00B, '0); req(1, 1'b0, 13'h00C, '0);
    serve(100);
    chk("t2_n", order.size(), 4);
    if (order.size() >= 3) begin
      chk("t2_first", order[0], 0);
      chk("t2_second", order[1], 1);
      chk("t2_third", order[2], 0);
    end
    @(negedge clk);
    chk("t2_cnt0", grant_cnt[0], 2);
    chk("t2_cnt1", grant_cnt[1], 2);
    tick();

    // 3: dcache writes a pattern, icache reads it back
    for (int unsigned i = 0; i < LS; i++) l[i] = 32'hA5A5_0000 + i;
    req(1, 1'b1, 13'h010, l);
    serve(100);
    req(0, 1'b0, 13'h010, '0);
    serve(100);
    for (int unsigned i = 0; i < LS; i++) chk("t3_word", got[0][i], 32'hA5A5_0000 + i);

    // 4: both hold requests continuously -> strict alternation
    order.delete();
    req(0, 1'b0, 13'h003, '0); req(1, 1'b0, 13'h004, '0);
    for (int n = 0; n < 300 && order.size() < 8; n++) begin
      @(negedge clk);
      if (c_gnt[0]) order.push_back(0);
      if (c_gnt[1]) order.push_back(1);
    end
    tick();
    drop(0); drop(1);
    chk("t4_n", order.size(), 8);
    for (int i = 1; i < order.size(); i++) chk("t4_alt", order[i], 1 - order[i-1]);
    c0 = 0;
    foreach (order[i]) if (order[i] == 0) c0++;
    chk("t4_balance", c0, 4);
    repeat (3) tick();

    // 5: icache aborts two cycles into BUSY; dcache is served next
    lat_min = 6; lat_max = 6;
    repeat (2) tick();
    c0 = cnt_m[0];
    order.delete();
    req(0, 1'b0, 13'h020, '0);
    tick(); tick();
    drop(0); req(1, 1'b0, 13'h021, '0);
    @(negedge clk); chk("t5_busy_still", m_rd_req, 1'b1);
    @(negedge clk); chk("t5_abort_idle", {m_rd_req, c_gnt}, 3'b000);
    tick();
    serve(100);
    chk("t5_n", order.size(), 1);
    if (order.size() > 0) chk("t5_who", order[0], 1);
    chk("t5_cnt0", grant_cnt[0], c0);
    repeat (3) tick();

    // 6: reset during BUSY, then a normal transaction
    req(0, 1'b0, 13'h005, '0);
    tick(); tick();
    rst = 1'b1; drop(0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_m_idle", {m_rd_req, m_wr_req, m_addr, c_gnt}, '0);
    chk("t6_cnt0", grant_cnt[0], 0);
    chk("t6_cnt1", grant_cnt[1], 0);
    lat_min = 0; lat_max = 2;
    repeat (2) tick();
    req(0, 1'b0, 13'h005, '0);
    serve(100);
    chk("t6_data", got[0], init_line(13'h005));
    @(negedge clk); chk("t6_cnt0_after", grant_cnt[0], 1);
    tick();

    // random traffic from both clients
    lat_min = 0; lat_max = 4;
    act = '{0, 0}; idle = '{0, 2};
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      g = c_gnt;
      tick();
      for (int k = 0; k < 2; k++) begin
        if (act[k]) begin
          if (g[k]) begin
            act[k] = 0; drop(k); idle[k] = int'($urandom_range(3, 0));
          end else if (!c_wr_req[k] && $urandom_range(39, 0) == 0) begin
            act[k] = 0; drop(k); idle[k] = 1;
          end
        end else if (idle[k] > 0) begin
          idle[k]--;
        end else begin
          for (int unsigned i = 0; i < LS; i++) l[i] = $urandom;
          act[k] = 1;
          req(k, $urandom_range(2, 0) == 0, AL'($urandom_range(15, 0)), l);
        end
      end
    end
    drop(0); drop(1);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
